board_ctrl: RTL and testbench

Move controller that owns the 8x8 chess board array consumed by the screen generator. It takes single-cycle key enable pulses from the debounced key stages and the game-active indication from the screen FSM. It moves a cursor, selects a source square, and commits piece moves. It updates turn, move count and game-over status, all in the system clock domain.

---
 rtl/board_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_board_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/board_ctrl.sv
// Chess move controller: owns the 8x8 board, cursor, source selection and move commit.
// Every output is a register; the board is indexed [row][col] with 4-bit square codes.
module board_ctrl (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  key_col,
  input  logic                  key_row,
  input  logic                  key_enter,
  output logic [7:0][7:0][3:0]  board,
  output logic [2:0]            cur_row,
  output logic [2:0]            cur_col,
  output logic                  sel_valid,
  output logic [2:0]            sel_row,
  output logic [2:0]            sel_col,
  output logic                  turn,
  output logic [7:0]            move_count,
  output logic                  move_done,
  output logic                  reject,
  output logic                  game_over
);

  typedef logic [7:0][7:0][3:0] board_t;
  typedef enum logic [1:0] {
    ST_SELECT = 2'd0,
    ST_DEST   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic logic [3:0] back_rank(input logic [2:0] col);
    case (col)
      3'd0, 3'd7: back_rank = 4'd0;
      3'd1, 3'd6: back_rank = 4'd1;
      3'd2, 3'd5: back_rank = 4'd2;
      3'd3:       back_rank = 4'd3;
      3'd4:       back_rank = 4'd4;
      default:    back_rank = 4'd15;
    endcase
  endfunction

  function automatic board_t init_board();
    board_t b;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        case (3'(r))
          3'd0:    b[r][c] = back_rank(3'(c));
          3'd1:    b[r][c] = 4'd5;
          3'd6:    b[r][c] = 4'd11;
          3'd7:    b[r][c] = back_rank(3'(c)) + 4'd6;
          default: b[r][c] = 4'd15;
        endcase
      end
    end
    return b;
  endfunction

  function automatic logic owned(input logic [3:0] code, input logic side);
    if (side == 1'b0) begin
      owned = (code <= 4'd5);
    end else begin
      owned = (code >= 4'd6) && (code <= 4'd11);
    end
  endfunction

  // Pawns reaching the far rank become queens of the same side.
  function automatic logic [3:0] promote(input logic [3:0] code, input logic [2:0] row);
    if ((code == 4'd5) && (row == 3'd7)) begin
      promote = 4'd3;
    end else if ((code == 4'd11) && (row == 3'd0)) begin
      promote = 4'd9;
    end else begin
      promote = code;
    end
  endfunction

  board_t      board_r;
  state_t      state_r;
  logic [2:0]  cur_row_r, cur_col_r, sel_row_r, sel_col_r, dst_row_r, dst_col_r;
  logic        sel_valid_r, turn_r, move_done_r, reject_r, game_over_r;
  logic [7:0]  move_count_r;

  logic        own_cur_s, at_src_s;
  logic [3:0]  dst_piece_s, placed_s;

  // Decode of the square under the cursor and the pending move.
  always_comb begin
    own_cur_s   = owned(board_r[cur_row_r][cur_col_r], turn_r);
    at_src_s    = (cur_row_r == sel_row_r) && (cur_col_r == sel_col_r);
    dst_piece_s = board_r[dst_row_r][dst_col_r];
    placed_s    = promote(board_r[sel_row_r][sel_col_r], dst_row_r);
  end

  // Cursor, selection FSM and board update; clear acts as a synchronous full restart.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      board_r      <= init_board();
      state_r      <= ST_SELECT;
      cur_row_r    <= 3'd0;
      cur_col_r    <= 3'd0;
      sel_row_r    <= 3'd0;
      sel_col_r    <= 3'd0;
      dst_row_r    <= 3'd0;
      dst_col_r    <= 3'd0;
      sel_valid_r  <= 1'b0;
      turn_r       <= 1'b0;
      move_count_r <= 8'd0;
      move_done_r  <= 1'b0;
      reject_r     <= 1'b0;
      game_over_r  <= 1'b0;
    end else if (clear) begin
      board_r      <= init_board();
      state_r      <= ST_SELECT;
      cur_row_r    <= 3'd0;
      cur_col_r    <= 3'd0;
      sel_row_r    <= 3'd0;
      sel_col_r    <= 3'd0;
      dst_row_r    <= 3'd0;
      dst_col_r    <= 3'd0;
      sel_valid_r  <= 1'b0;
      turn_r       <= 1'b0;
      move_count_r <= 8'd0;
      move_done_r  <= 1'b0;
      reject_r     <= 1'b0;
      game_over_r  <= 1'b0;
    end else begin
      move_done_r <= 1'b0;
      reject_r    <= 1'b0;
      if (enable) begin
        if (key_col) cur_col_r <= cur_col_r + 3'd1;
        if (key_row) cur_row_r <= cur_row_r + 3'd1;
      end
      case (state_r)
        ST_SELECT: begin
          if (enable && key_enter) begin
            if (own_cur_s) begin
              sel_row_r   <= cur_row_r;
              sel_col_r   <= cur_col_r;
              sel_valid_r <= 1'b1;
              state_r     <= ST_DEST;
            end else begin
              reject_r <= 1'b1;
            end
          end
        end
        ST_DEST: begin
          if (enable && key_enter) begin
            if (at_src_s) begin
              sel_valid_r <= 1'b0;
              sel_row_r   <= 3'd0;
              sel_col_r   <= 3'd0;
              state_r     <= ST_SELECT;
            end else if (own_cur_s) begin
              sel_row_r <= cur_row_r;
              sel_col_r <= cur_col_r;
            end else begin
              dst_row_r <= cur_row_r;
              dst_col_r <= cur_col_r;
              state_r   <= ST_COMMIT;
            end
          end
        end
        ST_COMMIT: begin
          board_r[dst_row_r][dst_col_r] <= placed_s;
          board_r[sel_row_r][sel_col_r] <= 4'd15;
          turn_r       <= ~turn_r;
          move_count_r <= move_count_r + 8'd1;
          sel_valid_r  <= 1'b0;
          sel_row_r    <= 3'd0;
          sel_col_r    <= 3'd0;
          move_done_r  <= 1'b1;
          if ((dst_piece_s == 4'd4) || (dst_piece_s == 4'd10)) begin
            game_over_r <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            state_r <= ST_SELECT;
          end
        end
        ST_DONE: begin
          if (enable && key_enter) reject_r <= 1'b1;
        end
        default: state_r <= ST_SELECT;
      endcase
    end
  end

  assign board      = board_r;
  assign cur_row    = cur_row_r;
  assign cur_col    = cur_col_r;
  assign sel_valid  = sel_valid_r;
  assign sel_row    = sel_row_r;
  assign sel_col    = sel_col_r;
  assign turn       = turn_r;
  assign move_count = move_count_r;
  assign move_done  = move_done_r;
  assign reject     = reject_r;
  assign game_over  = game_over_r;

endmodule

// File: tb/tb_board_ctrl.sv
// Directed bench for board_ctrl: a scripted game with hand-computed board states,
// covering cursor wrap, rejects, reselect/cancel, promotion, king capture and clear.
module tb_board_ctrl;

  logic                 clk;
  logic                 reset_n;
  logic                 enable;
  logic                 clear;
  logic                 key_col;
  logic                 key_row;
  logic                 key_enter;
  logic [7:0][7:0][3:0] board;
  logic [2:0]           cur_row, cur_col, sel_row, sel_col;
  logic                 sel_valid, turn, move_done, reject, game_over;
  logic [7:0]           move_count;

  int checks = 0;
  int errors = 0;
  int m_row  = 0;
  int m_col  = 0;

  board_ctrl dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
    .key_col(key_col), .key_row(key_row), .key_enter(key_enter),
    .board(board), .cur_row(cur_row), .cur_col(cur_col),
    .sel_valid(sel_valid), .sel_row(sel_row), .sel_col(sel_col),
    .turn(turn), .move_count(move_count), .move_done(move_done),
    .reject(reject), .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock with the given pulses; returns 1 time unit after the edge.
  task automatic step(input logic c, input logic r, input logic e);
    @(negedge clk);
    key_col   = c;
    key_row   = r;
    key_enter = e;
    @(posedge clk);
    #1;
    key_col   = 1'b0;
    key_row   = 1'b0;
    key_enter = 1'b0;
  endtask

  task automatic goto(input int tr, input int tc);
    while (m_col != tc) begin
      step(1'b1, 1'b0, 1'b0);
      m_col = (m_col + 1) % 8;
    end
    while (m_row != tr) begin
      step(1'b0, 1'b1, 1'b0);
      m_row = (m_row + 1) % 8;
    end
  endtask

  // Select source, pick destination, then let the COMMIT cycle run.
  task automatic do_move(input int sr, input int sc, input int dr, input int dc);
    goto(sr, sc);
    step(1'b0, 1'b0, 1'b1);
    goto(dr, dc);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b1; clear = 1'b0;
    key_col = 1'b0; key_row = 1'b0; key_enter = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_b00", board[0][0], 4'd0);
    check("rst_b04", board[0][4], 4'd4);
    check("rst_b13", board[1][3], 4'd5);
    check("rst_b33", board[3][3], 4'd15);
    check("rst_b62", board[6][2], 4'd11);
    check("rst_b74", board[7][4], 4'd10);
    check("rst_b77", board[7][7], 4'd6);
    check("rst_turn", turn, 1'b0);
    check("rst_cur", {cur_row, cur_col}, 6'd0);
    check("rst_sel", sel_valid, 1'b0);
    check("rst_cnt", move_count, 8'd0);
    check("rst_go", game_over, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // cursor wrap
    repeat (8) step(1'b1, 1'b0, 1'b0);
    check("col_wrap", cur_col, 3'd0);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    check("row_3", cur_row, 3'd3);
    m_row = 3; m_col = 0;

    // rejects in SELECT
    goto(4, 4);
    step(1'b0, 1'b0, 1'b1);
    check("rej_empty", reject, 1'b1);
    check("rej_empty_sel", sel_valid, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("rej_pulse_end", reject, 1'b0);
    goto(6, 0);
    step(1'b0, 1'b0, 1'b1);
    check("rej_enemy", reject, 1'b1);

    // reselect and cancel
    goto(1, 0);
    step(1'b0, 1'b0, 1'b1);
    check("sel_valid", sel_valid, 1'b1);
    check("sel_10", {sel_row, sel_col}, {3'd1, 3'd0});
    check("sel_no_rej", reject, 1'b0);
    goto(1, 1);
    step(1'b0, 1'b0, 1'b1);
    check("resel_11", {sel_row, sel_col}, {3'd1, 3'd1});
    step(1'b0, 1'b0, 1'b1);
    check("cancel_valid", sel_valid, 1'b0);
    check("cancel_pos", {sel_row, sel_col}, 6'd0);

    // legal move (1,4)->(3,4)
    goto(1, 4);
    step(1'b0, 1'b0, 1'b1);
    goto(3, 4);
    step(1'b0, 1'b0, 1'b1);
    check("pre_commit_b34", board[3][4], 4'd15);
    check("pre_commit_done", move_done, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("mv1_b34", board[3][4], 4'd5);
    check("mv1_b14", board[1][4], 4'd15);
    check("mv1_turn", turn, 1'b1);
    check("mv1_cnt", move_count, 8'd1);
    check("mv1_done", move_done, 1'b1);
    check("mv1_sel", sel_valid, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("mv1_done_end", move_done, 1'b0);

    // enable low drops pulses
    enable = 1'b0;
    step(1'b1, 1'b1, 1'b1);
    check("dis_cur", {cur_row, cur_col}, {3'd3, 3'd4});
    check("dis_rej", reject, 1'b0);
    enable = 1'b1;

    // enter together with key_col uses the old column
    goto(6, 3);
    step(1'b1, 1'b0, 1'b1);
    m_col = 4;
    check("combo_sel", {sel_row, sel_col}, {3'd6, 3'd3});
    check("combo_cur", cur_col, 3'd4);
    enable = 1'b0;
    step(1'b0, 1'b0, 1'b1);
    check("dis_keep_sel", {sel_valid, sel_row, sel_col}, {1'b1, 3'd6, 3'd3});
    enable = 1'b1;

    // side-1 pawn (6,3) onto row 0 promotes; enter during COMMIT is ignored
    goto(0, 3);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("commit_enter_rej", reject, 1'b0);
    check("promo1_b03", board[0][3], 4'd9);
    check("promo1_b63", board[6][3], 4'd15);
    check("mv2_cnt", move_count, 8'd2);
    check("mv2_turn", turn, 1'b0);

    do_move(3, 4, 7, 3);
    check("promo0_b73", board[7][3], 4'd3);
    check("promo0_b34", board[3][4], 4'd15);
    do_move(6, 0, 5, 0);
    check("mv4_b50", board[5][0], 4'd11);
    check("mv4_cnt", move_count, 8'd4);
    check("mv4_go", game_over, 1'b0);

    // queen takes side-1 king
    do_move(7, 3, 7, 4);
    check("king_go", game_over, 1'b1);
    check("king_b74", board[7][4], 4'd3);
    check("king_cnt", move_count, 8'd5);
    check("king_turn", turn, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    m_col = 5;
    check("done_cursor", cur_col, 3'd5);
    step(1'b0, 1'b0, 1'b1);
    check("done_rej", reject, 1'b1);
    check("done_sel", sel_valid, 1'b0);

    // clear restores everything
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    m_row = 0; m_col = 0;
    check("clr_b74", board[7][4], 4'd10);
    check("clr_b03", board[0][3], 4'd3);
    check("clr_b14", board[1][4], 4'd5);
    check("clr_go", game_over, 1'b0);
    check("clr_cnt", move_count, 8'd0);
    check("clr_turn", turn, 1'b0);
    check("clr_cur", {cur_row, cur_col}, 6'd0);

    // asynchronous reset while in COMMIT
    goto(1, 0);
    step(1'b0, 1'b0, 1'b1);
    goto(2, 0);
    step(1'b0, 1'b0, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_sel", sel_valid, 1'b0);
    check("arst_cur", {cur_row, cur_col}, 6'd0);
    @(posedge clk);
    #1;
    check("arst_b20", board[2][0], 4'd15);
    check("arst_b10", board[1][0], 4'd5);
    check("arst_cnt", move_count, 8'd0);
    check("arst_done", move_done, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
